pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Centralised hazard and pipeline-control block for the 5-stage RV32I core. It replaces the tied-off `stall`/`flush` nets in the core top. Each cycle it computes:
- stall, flush and bubble controls for every pipeline register;
- EX-stage operand forwarding selects.

It adds a parametrised multi-cycle data-memory wait FSM and wrapping performance counters.

## Interface
- `REG_AW`, 5: register-index width; index 0 is hard-wired zero.
- `MEM_LAT`, 1: extra wait cycles per dmem access, 0..15; 0 means single-cycle memory.
- `CNT_W`, 32: performance counter width.

- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high.
- `id_rs1`, `id_rs2` in REG_AW: source indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction reads that source.
- `ex_rs1`, `ex_rs2`, `ex_rd` in REG_AW: indices held in ID/EX.
- `ex_RegWrite`, `ex_MemRead` in 1: ID/EX controls.
- `ex_redirect` in 1: a branch is taken or JAL/JALR is resolved in EX.
- `mem_rd` in REG_AW; `mem_RegWrite`, `mem_MemRead`, `mem_MemWrite` in 1: EX/MEM contents.
- `wb_rd` in REG_AW; `wb_RegWrite` in 1: MEM/WB contents.
- `stall_pc`, `stall_if_id`, `stall_id_ex`, `stall_ex_mem` out 1: hold the register.
- `flush_if_id`, `flush_id_ex`, `flush_mem_wb` out 1: load a bubble on the next edge.
- `fwd_a`, `fwd_b` out 2: ALU operand source. 00 = ID/EX value, 01 = WB write data, 10 = EX/MEM ALU result.
- `mem_busy` out 1: the wait FSM is holding MEM.
- `stall_cycles`, `flush_events` out CNT_W: performance counters.

## Operation
- **Forwarding (combinational).** `fwd_a = 10` if `mem_RegWrite && !mem_MemRead && mem_rd != 0 && mem_rd == ex_rs1`. Otherwise `01` if `wb_RegWrite && wb_rd != 0 && wb_rd == ex_rs1`. Otherwise `00`. `fwd_b` uses the same rule with `ex_rs2`. MEM beats WB.
- **Load-use.** `lu = ex_MemRead && ex_RegWrite && ex_rd != 0` and (`id_use_rs1 && id_rs1 == ex_rd` or `id_use_rs2 && id_rs2 == ex_rd`).
- **Mem wait FSM.** States IDLE and WAIT; 4-bit `cnt`.
  - IDLE, `(mem_MemRead | mem_MemWrite)` and `MEM_LAT > 0`: set `ms = 1`, `cnt <= MEM_LAT-1`, go to WAIT.
  - WAIT: `ms = (cnt != 0)`. Decrement while nonzero. Return to IDLE in the cycle `cnt == 0`, in which `ms = 0` and the access retires.
  - Result: each access stays in MEM for exactly MEM_LAT+1 cycles. `mem_busy = ms`.
  - With `MEM_LAT = 0` the FSM never leaves IDLE.
- **Control priority.** The first matching row applies:
  1. `ms`: all four `stall_*` = 1; `flush_mem_wb` = 1; every other flush = 0. `ex_redirect` and `lu` are ignored, because EX is frozen and re-presents them later.
  2. `ex_redirect`: `flush_if_id = flush_id_ex = 1`; no stalls. A coincident `lu` is discarded, since the ID instruction is wrong-path.
  3. `lu`: `stall_pc = stall_if_id = 1`, `flush_id_ex = 1`.
  4. Otherwise all controls are 0.
- **Counters.** Both counters wrap at 2^CNT_W.
  - `stall_cycles` increments on every cycle in which any `stall_*` is 1.
  - `flush_events` increments on every cycle in which priority row 2 applies.

## Timing
- Reset values: FSM IDLE, `cnt = 0`, `stall_cycles = flush_events = 0`.
- Control outputs are combinational from inputs and FSM state, so their values while reset is held follow from IDLE.
- Forwarding, stall and flush decisions are zero-latency, valid in the same cycle as their inputs. Consumers act on them at the next `clk` edge.
- Counters update on the edge ending the qualifying cycle. FSM and counters update on `clk` rising edges only.
- Load-use costs exactly 1 bubble. A redirect costs exactly 2 bubbles. A dmem access costs MEM_LAT bubbles into WB.
- Back-to-back accesses: a new access arriving in the cycle after retirement finds IDLE and starts a fresh wait. There is no overlap.
- Reset asserted mid-WAIT forces IDLE immediately and clears `ms`. After release the next access waits the full MEM_LAT.

## Test plan
- `ex_rd = 5`, `ex_RegWrite = 1` reaching MEM while `ex_rs1 = 5`, plus WB writing `x5` → `fwd_a = 10`. With `mem_rd = 0` and `wb_rd = 5`, `wb_RegWrite = 1` → `fwd_a = 01`. With `rd = 0` → `00`.
- `lw x3` in EX (`ex_MemRead = 1`, `ex_rd = 3`), `id_rs2 = 3`, `id_use_rs2 = 1` → `stall_pc = stall_if_id = flush_id_ex = 1` for 1 cycle; `stall_cycles` goes 0 → 1.
- `ex_redirect = 1` with the load-use condition also true → only `flush_if_id = flush_id_ex = 1`; `flush_events` = 1; `stall_cycles` unchanged.
- `MEM_LAT = 3`, `mem_MemRead` held → `ms` and `flush_mem_wb` = 1 for 3 cycles, 0 on the 4th. A concurrent `ex_redirect` produces no flush of IF/ID during those 3 cycles.
- `MEM_LAT = 2`, reset pulsed during the first WAIT cycle → FSM IDLE and stalls drop immediately. A new access after release waits 2 more cycles. Counters read 0 after reset.
- `MEM_LAT = 0`, consecutive loads and stores → `mem_busy` never asserts; `stall_cycles` stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Brief    : Pipeline-state and control bundle between the RV32I core
//             datapath (master) and the hazard controller (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  // ID stage
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  // ID/EX register
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_RegWrite;
  logic              ex_MemRead;
  logic              ex_redirect;
  // EX/MEM register
  logic [REG_AW-1:0] mem_rd;
  logic              mem_RegWrite;
  logic              mem_MemRead;
  logic              mem_MemWrite;
  // MEM/WB register
  logic [REG_AW-1:0] wb_rd;
  logic              wb_RegWrite;
  // Controls back to the pipeline
  logic              stall_pc;
  logic              stall_if_id;
  logic              stall_id_ex;
  logic              stall_ex_mem;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              flush_mem_wb;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mem_busy;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;

  // Core datapath side
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_RegWrite, ex_MemRead, ex_redirect,
    output mem_rd, mem_RegWrite, mem_MemRead, mem_MemWrite,
    output wb_rd, wb_RegWrite,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    input  flush_if_id, flush_id_ex, flush_mem_wb,
    input  fwd_a, fwd_b, mem_busy, stall_cycles, flush_events
  );

  // Hazard controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_RegWrite, ex_MemRead, ex_redirect,
    input  mem_rd, mem_RegWrite, mem_MemRead, mem_MemWrite,
    input  wb_rd, wb_RegWrite,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    output flush_if_id, flush_id_ex, flush_mem_wb,
    output fwd_a, fwd_b, mem_busy, stall_cycles, flush_events
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Hazard and pipeline-control unit for the 5-stage RV32I core:
//             EX operand forwarding, load-use interlock, redirect flush,
//             multi-cycle dmem wait FSM and wrapping performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input wire                clk,
  input wire                reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [REG_AW-1:0] C_REG_ZERO  = '0;
  localparam bit                C_HAS_WAIT  = (MEM_LAT > 0);
  localparam int                C_LAT_M1_I  = (MEM_LAT > 0) ? (MEM_LAT - 1) : 0;
  localparam logic [3:0]        C_LAT_M1    = C_LAT_M1_I[3:0];
  localparam logic [CNT_W-1:0]  C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  logic       w_mem_acc;
  logic       w_ms;
  logic       w_lu;
  logic       w_mem_fwd_ok;
  logic       w_wb_fwd_ok;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_stall_pc;
  logic       w_stall_if_id;
  logic       w_stall_id_ex;
  logic       w_stall_ex_mem;
  logic       w_flush_if_id;
  logic       w_flush_id_ex;
  logic       w_flush_mem_wb;
  logic       w_redirect_evt;

  // Operand forwarding: a load result is not yet available in EX/MEM, so MEM forwarding excludes loads; MEM beats WB.
  always_comb begin
    w_mem_fwd_ok = bus.mem_RegWrite && !bus.mem_MemRead && (bus.mem_rd != C_REG_ZERO);
    w_wb_fwd_ok  = bus.wb_RegWrite && (bus.wb_rd != C_REG_ZERO);
    w_fwd_a      = 2'b00;
    w_fwd_b      = 2'b00;
    if (w_mem_fwd_ok && (bus.mem_rd == bus.ex_rs1)) begin
      w_fwd_a = 2'b10;
    end else if (w_wb_fwd_ok && (bus.wb_rd == bus.ex_rs1)) begin
      w_fwd_a = 2'b01;
    end
    if (w_mem_fwd_ok && (bus.mem_rd == bus.ex_rs2)) begin
      w_fwd_b = 2'b10;
    end else if (w_wb_fwd_ok && (bus.wb_rd == bus.ex_rs2)) begin
      w_fwd_b = 2'b01;
    end
  end

  // Load-use detection: a load in EX feeding a source the ID instruction actually reads.
  always_comb begin
    w_lu = bus.ex_MemRead && bus.ex_RegWrite && (bus.ex_rd != C_REG_ZERO) &&
           ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
            (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
  end

  // Dmem wait FSM: the first cycle of an access already stalls, so an access occupies MEM for MEM_LAT+1 cycles.
  always_comb begin
    w_mem_acc = bus.mem_MemRead || bus.mem_MemWrite;
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_ms      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_mem_acc && C_HAS_WAIT) begin
          w_ms    = 1'b1;
          cnt_d   = C_LAT_M1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          w_ms  = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control priority: mem wait freezes everything, then redirect, then load-use interlock.
  always_comb begin
    w_stall_pc     = 1'b0;
    w_stall_if_id  = 1'b0;
    w_stall_id_ex  = 1'b0;
    w_stall_ex_mem = 1'b0;
    w_flush_if_id  = 1'b0;
    w_flush_id_ex  = 1'b0;
    w_flush_mem_wb = 1'b0;
    w_redirect_evt = 1'b0;
    if (w_ms) begin
      // EX is frozen; any redirect or load-use there is re-presented after the wait.
      w_stall_pc     = 1'b1;
      w_stall_if_id  = 1'b1;
      w_stall_id_ex  = 1'b1;
      w_stall_ex_mem = 1'b1;
      w_flush_mem_wb = 1'b1;
    end else if (bus.ex_redirect) begin
      // The ID instruction is wrong-path, so a coincident load-use is irrelevant.
      w_flush_if_id  = 1'b1;
      w_flush_id_ex  = 1'b1;
      w_redirect_evt = 1'b1;
    end else if (w_lu) begin
      w_stall_pc     = 1'b1;
      w_stall_if_id  = 1'b1;
      w_flush_id_ex  = 1'b1;
    end
  end

  // Performance counter next values; both wrap naturally at 2^CNT_W.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (w_stall_pc || w_stall_if_id || w_stall_id_ex || w_stall_ex_mem) begin
      stall_cycles_d = stall_cycles_q + C_CNT_ONE;
    end
    if (w_redirect_evt) begin
      flush_events_d = flush_events_q + C_CNT_ONE;
    end
  end

  // State and counter registers; reset forces IDLE immediately so ms drops without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign bus.fwd_a        = w_fwd_a;
  assign bus.fwd_b        = w_fwd_b;
  assign bus.stall_pc     = w_stall_pc;
  assign bus.stall_if_id  = w_stall_if_id;
  assign bus.stall_id_ex  = w_stall_id_ex;
  assign bus.stall_ex_mem = w_stall_ex_mem;
  assign bus.flush_if_id  = w_flush_if_id;
  assign bus.flush_id_ex  = w_flush_id_ex;
  assign bus.flush_mem_wb = w_flush_mem_wb;
  assign bus.mem_busy     = w_ms;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_events = flush_events_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Directed testbench for pipe_hazard_ctrl. Three instances share
//             the same stimulus with MEM_LAT = 3, 2 and 0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;
  localparam int N_DUT  = 3;
  localparam int I_L3   = 0;
  localparam int I_L2   = 1;
  localparam int I_L0   = 2;

  // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb}
  localparam logic [6:0] C_NONE = 7'b0000_000;
  localparam logic [6:0] C_LU   = 7'b1100_010;
  localparam logic [6:0] C_RED  = 7'b0000_110;
  localparam logic [6:0] C_MS   = 7'b1111_001;

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_RegWrite;
    logic       ex_MemRead;
    logic       ex_redirect;
    logic [4:0] mem_rd;
    logic       mem_RegWrite;
    logic       mem_MemRead;
    logic       mem_MemWrite;
    logic [4:0] wb_rd;
    logic       wb_RegWrite;
  } in_t;

  typedef struct packed {
    logic [6:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
  } out_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [6:0] ctl;
  } vec_t;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  in_t              din;
  out_t             dout [N_DUT];
  logic [CNT_W-1:0] sc   [N_DUT];
  logic [CNT_W-1:0] fe   [N_DUT];

  int n_cmp = 0;
  int n_err = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 3 : ((g == 1) ? 2 : 0);
    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();
    assign bus.id_rs1       = din.id_rs1;
    assign bus.id_rs2       = din.id_rs2;
    assign bus.id_use_rs1   = din.id_use_rs1;
    assign bus.id_use_rs2   = din.id_use_rs2;
    assign bus.ex_rs1       = din.ex_rs1;
    assign bus.ex_rs2       = din.ex_rs2;
    assign bus.ex_rd        = din.ex_rd;
    assign bus.ex_RegWrite  = din.ex_RegWrite;
    assign bus.ex_MemRead   = din.ex_MemRead;
    assign bus.ex_redirect  = din.ex_redirect;
    assign bus.mem_rd       = din.mem_rd;
    assign bus.mem_RegWrite = din.mem_RegWrite;
    assign bus.mem_MemRead  = din.mem_MemRead;
    assign bus.mem_MemWrite = din.mem_MemWrite;
    assign bus.wb_rd        = din.wb_rd;
    assign bus.wb_RegWrite  = din.wb_RegWrite;
    assign dout[g] = {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem,
                      bus.flush_if_id, bus.flush_id_ex, bus.flush_mem_wb,
                      bus.fwd_a, bus.fwd_b, bus.mem_busy};
    assign sc[g] = bus.stall_cycles;
    assign fe[g] = bus.flush_events;
    pipe_hazard_ctrl #(.REG_AW(REG_AW), .MEM_LAT(LAT), .CNT_W(CNT_W)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  function automatic void add(input string n, input in_t i, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [6:0] c);
    vec_t v;
    v.name = n; v.in = i; v.fa = fa; v.fb = fb; v.ctl = c;
    vq.push_back(v);
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    din   = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < N_DUT; k++) begin
      check($sformatf("rst_sc%0d", k), 64'(sc[k]), 64'd0);
      check($sformatf("rst_fe%0d", k), 64'(fe[k]), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_t t;
    int  exp_sc;
    int  exp_fe;
    logic exp_busy [6];

    // ---------------- vector table ----------------
    t = '0; add("idle", t, 2'b00, 2'b00, C_NONE);
    t = '0; t.ex_rs1 = 5; t.mem_rd = 5; t.mem_RegWrite = 1; t.wb_rd = 5; t.wb_RegWrite = 1;
    add("fwd_a_mem_beats_wb", t, 2'b10, 2'b00, C_NONE);
    t.mem_rd = 0;
    add("fwd_a_wb", t, 2'b01, 2'b00, C_NONE);
    t.wb_rd = 0; t.ex_rs1 = 0;
    add("fwd_a_x0", t, 2'b00, 2'b00, C_NONE);
    t = '0; t.ex_rs1 = 9; t.ex_rs2 = 9; t.mem_rd = 9; t.mem_RegWrite = 1; t.wb_rd = 9; t.wb_RegWrite = 1;
    add("fwd_ab_mem", t, 2'b10, 2'b10, C_NONE);
    t = '0; t.ex_rs1 = 30; t.ex_rs2 = 31; t.mem_rd = 30; t.wb_rd = 31; t.wb_RegWrite = 1;
    add("fwd_b_wb_mem_nowrite", t, 2'b00, 2'b01, C_NONE);
    t = '0; t.ex_MemRead = 1; t.ex_RegWrite = 1; t.ex_rd = 3; t.id_rs2 = 3; t.id_use_rs2 = 1;
    add("lu_rs2", t, 2'b00, 2'b00, C_LU);
    t.id_use_rs2 = 0;
    add("lu_rs2_unused", t, 2'b00, 2'b00, C_NONE);
    t.id_rs1 = 3; t.id_use_rs1 = 1;
    add("lu_rs1", t, 2'b00, 2'b00, C_LU);
    t.ex_rd = 0; t.id_rs1 = 0;
    add("lu_rd_x0", t, 2'b00, 2'b00, C_NONE);
    t = '0; t.ex_MemRead = 1; t.ex_rd = 4; t.id_rs1 = 4; t.id_use_rs1 = 1;
    add("lu_no_regwrite", t, 2'b00, 2'b00, C_NONE);
    t = '0; t.ex_MemRead = 1; t.ex_RegWrite = 1; t.ex_rd = 3; t.id_rs2 = 2; t.id_use_rs2 = 1;
    add("lu_index_mismatch", t, 2'b00, 2'b00, C_NONE);
    t = '0; t.ex_RegWrite = 1; t.ex_rd = 6; t.id_rs1 = 6; t.id_use_rs1 = 1;
    add("alu_dep_no_stall", t, 2'b00, 2'b00, C_NONE);
    t = '0; t.ex_redirect = 1;
    add("redirect", t, 2'b00, 2'b00, C_RED);
    t = '0; t.ex_redirect = 1; t.ex_MemRead = 1; t.ex_RegWrite = 1; t.ex_rd = 3; t.id_rs2 = 3; t.id_use_rs2 = 1;
    add("redirect_over_lu", t, 2'b00, 2'b00, C_RED);

    // ---------------- reset state ----------------
    din   = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < N_DUT; k++) begin
      check($sformatf("reset_ctl%0d", k), 64'(dout[k].ctl), 64'(C_NONE));
      check($sformatf("reset_busy%0d", k), 64'(dout[k].busy), 64'd0);
      check($sformatf("reset_sc%0d", k), 64'(sc[k]), 64'd0);
      check($sformatf("reset_fe%0d", k), 64'(fe[k]), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table-driven vectors (no dmem access) ----------------
    exp_sc = 0;
    exp_fe = 0;
    foreach (vq[i]) begin
      @(negedge clk);
      din = vq[i].in;
      #1;
      check({vq[i].name, "_fwd_a"}, 64'(dout[I_L3].fa),  64'(vq[i].fa));
      check({vq[i].name, "_fwd_b"}, 64'(dout[I_L3].fb),  64'(vq[i].fb));
      check({vq[i].name, "_ctl"},   64'(dout[I_L3].ctl), 64'(vq[i].ctl));
      if (vq[i].ctl[6:3] != 4'b0000) exp_sc++;
      if (vq[i].ctl == C_RED)        exp_fe++;
    end
    @(negedge clk);
    din = '0;
    #1;
    check("table_stall_cycles", 64'(sc[I_L3]), 64'(exp_sc));
    check("table_flush_events", 64'(fe[I_L3]), 64'(exp_fe));

    // ---------------- MEM_LAT=3 wait with concurrent redirect ----------------
    pulse_reset();
    @(negedge clk);
    din = '0;
    din.mem_MemRead = 1; din.ex_redirect = 1;
    din.mem_rd = 7; din.mem_RegWrite = 1; din.ex_rs2 = 7; din.wb_rd = 7; din.wb_RegWrite = 1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check($sformatf("lat3_ctl_c%0d", c),  64'(dout[I_L3].ctl),  64'((c < 3) ? C_MS : C_RED));
      check($sformatf("lat3_busy_c%0d", c), 64'(dout[I_L3].busy), 64'((c < 3) ? 1 : 0));
      check($sformatf("load_no_mem_fwd_c%0d", c), 64'(dout[I_L3].fb), 64'(2'b01));
      check($sformatf("lat0_ctl_c%0d", c),  64'(dout[I_L0].ctl),  64'(C_RED));
      check($sformatf("lat0_busy_c%0d", c), 64'(dout[I_L0].busy), 64'd0);
    end
    @(negedge clk);
    din = '0;
    #1;
    check("lat3_stall_cycles", 64'(sc[I_L3]), 64'd3);
    check("lat3_flush_events", 64'(fe[I_L3]), 64'd1);
    check("lat0_stall_cycles", 64'(sc[I_L0]), 64'd0);
    check("lat0_flush_events", 64'(fe[I_L0]), 64'd4);

    // ---------------- MEM_LAT=2 back-to-back accesses ----------------
    pulse_reset();
    exp_busy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    din.mem_MemRead = 1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check($sformatf("b2b_busy_c%0d", c), 64'(dout[I_L2].busy), 64'(exp_busy[c]));
      check($sformatf("b2b_ctl_c%0d", c),  64'(dout[I_L2].ctl),  64'(exp_busy[c] ? C_MS : C_NONE));
    end
    @(negedge clk);
    din = '0;
    #1;
    check("b2b_stall_cycles", 64'(sc[I_L2]), 64'd4);

    // ---------------- MEM_LAT=2 reset during first WAIT cycle ----------------
    pulse_reset();
    @(negedge clk);
    din.mem_MemRead = 1;
    #1;
    check("rstwait_busy_idle", 64'(dout[I_L2].busy), 64'd1);
    @(negedge clk);
    #1;
    check("rstwait_busy_wait", 64'(dout[I_L2].busy), 64'd1);
    #2;
    reset = 1'b1;
    din   = '0;
    #1;
    check("rstwait_busy_drop", 64'(dout[I_L2].busy), 64'd0);
    check("rstwait_ctl_drop",  64'(dout[I_L2].ctl),  64'(C_NONE));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstwait_sc", 64'(sc[I_L2]), 64'd0);
    check("rstwait_fe", 64'(fe[I_L2]), 64'd0);
    @(negedge clk);
    din.mem_MemWrite = 1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check($sformatf("postrst_busy_c%0d", c), 64'(dout[I_L2].busy), 64'((c < 2) ? 1 : 0));
    end
    @(negedge clk);
    din = '0;
    #1;
    check("postrst_stall_cycles", 64'(sc[I_L2]), 64'd2);

    // ---------------- MEM_LAT=0 consecutive loads and stores ----------------
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      din = '0;
      din.mem_MemRead  = (c % 2 == 0);
      din.mem_MemWrite = (c % 2 == 1);
      din.mem_rd       = 5'(c + 1);
      din.mem_RegWrite = (c % 2 == 0);
      #1;
      check($sformatf("lat0_ldst_busy_c%0d", c), 64'(dout[I_L0].busy), 64'd0);
      check($sformatf("lat0_ldst_ctl_c%0d", c),  64'(dout[I_L0].ctl),  64'(C_NONE));
    end
    @(negedge clk);
    din = '0;
    #1;
    check("lat0_ldst_stall_cycles", 64'(sc[I_L0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
